sort_seq_ctrl: RTL

Sequential sorting engine: accepts DIM unsigned elements over a valid/ready stream, sorts them in place with one shared compare-exchange unit under FSM control (bubble-sort pass schedule), then streams the sorted result out ascending. It is the clocked, area-cheap counterpart to the fully combinational sorter network, for cases where one comparator per cycle is enough.

---
 rtl/sort_seq_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sort_seq_ctrl.sv
// sort_seq_ctrl
//   Sequential sorting engine. Loads DIM unsigned elements over a valid/ready
//   stream, sorts them in place with a single compare-exchange unit
//   (bubble-sort pass schedule, one compare per cycle), then streams the
//   result out in ascending order.
//
//   Build option: define SORT_EARLY_EXIT_EN to end SORT after the first pass
//   that performs no swap. Without it SORT always takes DIM*(DIM-1)/2 cycles.
//   The output data is identical in both builds.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input element valid
//   in_ready   engine accepts input (LOAD only)
//   in_data    input element [WIDTH]
//   out_valid  sorted element valid (DRAIN only)
//   out_ready  downstream accepts output
//   out_data   sorted element [WIDTH], ascending; 0 outside DRAIN
//   out_last   high with the DIM-th (largest) element
//   busy       high in SORT and DRAIN
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_LOAD  | accept DIM elements into mem, idx counts them
// S_SORT  | one compare-exchange of mem[j], mem[j+1] per cycle
// S_DRAIN | present mem[idx] until accepted, idx counts outputs

module sort_seq_ctrl #(
  parameter int DIM   = 10,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int IW = $clog2(DIM);
  localparam logic [IW-1:0] LAST = IW'(DIM - 1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SORT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_j;
  logic [IW-1:0]    r_lim;
  logic             r_swapped;
  logic [WIDTH-1:0] r_mem [DIM];

  logic [IW-1:0]    w_j1;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_swap;
  logic             w_pass_end;
  logic             w_sort_done;
  logic             w_load_acc;

  assign w_j1       = r_j + 1'b1;
  assign w_a        = r_mem[r_j];
  assign w_b        = r_mem[w_j1];
  // Strict compare keeps equal keys in place, which makes the sort stable.
  assign w_swap     = (r_state == S_SORT) && (w_a > w_b);
  assign w_pass_end = (r_j == r_lim - 1'b1);
  assign w_load_acc = (r_state == S_LOAD) && in_valid;

`ifdef SORT_EARLY_EXIT_EN
  // A pass with no swap (this cycle's compare included) proves the array sorted.
  assign w_sort_done = w_pass_end && ((r_lim == IW'(1)) || !(r_swapped || w_swap));
`else
  assign w_sort_done = w_pass_end && (r_lim == IW'(1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_LOAD;
      r_idx     <= '0;
      r_j       <= '0;
      r_lim     <= LAST;
      r_swapped <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_acc) begin
            if (r_idx == LAST) begin
              r_state   <= S_SORT;
              r_idx     <= '0;
              r_j       <= '0;
              r_lim     <= LAST;
              r_swapped <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_SORT: begin
          if (w_pass_end) begin
            r_j       <= '0;
            r_lim     <= r_lim - 1'b1;
            r_swapped <= 1'b0;
            if (w_sort_done) begin
              r_state <= S_DRAIN;
              r_idx   <= '0;
              r_lim   <= LAST;
            end
          end else begin
            r_j       <= w_j1;
            r_swapped <= r_swapped | w_swap;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_idx == LAST) begin
              r_state <= S_LOAD;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Element storage is deliberately not reset; a reset only discards the job.
  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_mem[r_idx] <= in_data;
    end else if (w_swap) begin
      r_mem[r_j]  <= w_b;
      r_mem[w_j1] <= w_a;
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_DRAIN);
  assign out_data  = (r_state == S_DRAIN) ? r_mem[r_idx] : '0;
  assign out_last  = (r_state == S_DRAIN) && (r_idx == LAST);
  assign busy      = (r_state == S_SORT) || (r_state == S_DRAIN);

endmodule
